cmd_sequencer: RTL

Command sequencer between the host-write input FIFO and the Bus Pirate I/O buffers. It pops 16-bit command words from the input FIFO and executes them one at a time. Execution drives the MOSI, CLOCK, CS and AUX pin data lines and samples MISO. Bytes read back from the bus are pushed into the output FIFO for host reads.

---
 rtl/cmd_sequencer.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/cmd_sequencer.sv
// cmd_sequencer: pops 16-bit command words {opcode, arg} from the host input
// FIFO and executes them one at a time. It drives the CS, AUX, MOSI and SCK
// buffer lines, samples MISO, and pushes XFER results to the output FIFO.
//
// Optional feature: define SEQ_SPI_MODE_EN to add opcode 0x31, which selects
// CPOL/CPHA. Without it the shifter is fixed to SPI mode 0 and 0x31 is an
// unknown opcode.
module cmd_sequencer #(
  parameter logic [7:0] DIV_RESET = 8'd3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_nempty,
  input  logic [15:0] in_data,
  output logic        in_pop,
  input  logic        out_full,
  output logic        out_shift,
  output logic [15:0] out_data,
  input  logic        miso,
  output logic        mosi,
  output logic        sck,
  output logic        cs,
  output logic        aux,
  output logic        busy,
  output logic        error
);

  // FSM encoding
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_EXEC     = 3'd1;
  localparam logic [2:0] ST_SHIFT_LO = 3'd2;
  localparam logic [2:0] ST_SHIFT_HI = 3'd3;
  localparam logic [2:0] ST_PUSH     = 3'd4;
  localparam logic [2:0] ST_DELAY    = 3'd5;

  // Opcodes
  localparam logic [7:0] OP_CS_LO  = 8'h01;
  localparam logic [7:0] OP_CS_HI  = 8'h02;
  localparam logic [7:0] OP_AUX    = 8'h03;
  localparam logic [7:0] OP_WRITE  = 8'h10;
  localparam logic [7:0] OP_XFER   = 8'h11;
  localparam logic [7:0] OP_DELAY  = 8'h20;
  localparam logic [7:0] OP_DIV    = 8'h30;
  localparam logic [7:0] OP_MODE   = 8'h31;
  localparam logic [7:0] OP_CLRERR = 8'h3F;

  logic [2:0]  state_reg,    state_next;
  logic [15:0] cmd_reg,      cmd_next;
  logic [7:0]  div_reg,      div_next;
  logic [7:0]  cnt_reg,      cnt_next;     // divider phase count, or delay count
  logic [2:0]  bit_reg,      bit_next;     // current bit index, MSB first
  logic [7:0]  rx_reg,       rx_next;
  logic        mosi_reg,     mosi_next;
  logic        sck_reg,      sck_next;
  logic        cs_reg,       cs_next;
  logic        aux_reg,      aux_next;
  logic        error_reg,    error_next;
  logic [15:0] out_data_reg, out_data_next;

  logic [7:0] opcode;
  logic [7:0] arg;
  logic [7:0] rx_shifted;
  logic       cpol;
  logic       cpha;
  logic       mode_op_hit;

  assign opcode     = cmd_reg[15:8];
  assign arg        = cmd_reg[7:0];
  assign rx_shifted = {rx_reg[6:0], miso};

`ifdef SEQ_SPI_MODE_EN
  logic cpol_reg;
  logic cpha_reg;

  assign cpol        = cpol_reg;
  assign cpha        = cpha_reg;
  assign mode_op_hit = (opcode == OP_MODE);

  // Mode register: only written by an EXEC of opcode 0x31, so a byte in flight never sees a change
  always_ff @(posedge clock) begin
    if (reset) begin
      cpol_reg <= 1'b0;
      cpha_reg <= 1'b0;
    end else if (state_reg == ST_EXEC && opcode == OP_MODE) begin
      cpol_reg <= arg[1];
      cpha_reg <= arg[0];
    end
  end
`else
  assign cpol        = 1'b0;
  assign cpha        = 1'b0;
  assign mode_op_hit = 1'b0;
`endif

  // Handshake strobes are combinational so the pop/push lands on the same edge
  // that the FSM consumes or retires the word; reset masks them immediately.
  assign in_pop    = (state_reg == ST_IDLE) && in_nempty && !reset;
  assign out_shift = (state_reg == ST_PUSH) && !out_full && !reset;
  assign busy      = (state_reg != ST_IDLE);
  assign out_data  = out_data_reg;
  assign mosi      = mosi_reg;
  assign sck       = sck_reg;
  assign cs        = cs_reg;
  assign aux       = aux_reg;
  assign error     = error_reg;

  // Next-state and datapath decode for the command FSM
  always_comb begin
    state_next    = state_reg;
    cmd_next      = cmd_reg;
    div_next      = div_reg;
    cnt_next      = cnt_reg;
    bit_next      = bit_reg;
    rx_next       = rx_reg;
    mosi_next     = mosi_reg;
    sck_next      = sck_reg;
    cs_next       = cs_reg;
    aux_next      = aux_reg;
    error_next    = error_reg;
    out_data_next = out_data_reg;

    case (state_reg)
      ST_IDLE: begin
        if (in_nempty) begin
          cmd_next   = in_data;
          state_next = ST_EXEC;
        end
      end

      ST_EXEC: begin
        state_next = ST_IDLE;
        case (opcode)
          OP_CS_LO:  cs_next  = 1'b0;
          OP_CS_HI:  cs_next  = 1'b1;
          OP_AUX:    aux_next = arg[0];
          OP_WRITE, OP_XFER: begin
            // Divider is sampled here, so a DIV change only affects later bytes
            state_next = ST_SHIFT_LO;
            cnt_next   = div_reg;
            bit_next   = 3'd7;
            sck_next   = cpol;
            if (!cpha) begin
              mosi_next = arg[7];
            end
          end
          OP_DELAY: begin
            cnt_next   = arg;
            state_next = ST_DELAY;
          end
          OP_DIV:    div_next   = arg;
          OP_CLRERR: error_next = 1'b0;
          default: begin
            if (mode_op_hit) begin
              // Idle clock level follows the newly selected CPOL
              sck_next = arg[1];
            end else begin
              error_next = 1'b1;
            end
          end
        endcase
      end

      // First half of each bit: sck at its idle level
      ST_SHIFT_LO: begin
        if (cnt_reg == 8'd0) begin
          state_next = ST_SHIFT_HI;
          sck_next   = ~cpol;
          cnt_next   = div_reg;
          if (!cpha) begin
            rx_next = rx_shifted;
          end else begin
            mosi_next = arg[bit_reg];
          end
        end else begin
          cnt_next = cnt_reg - 8'd1;
        end
      end

      // Second half of each bit: sck at its active level
      ST_SHIFT_HI: begin
        if (cnt_reg == 8'd0) begin
          sck_next = cpol;
          if (cpha) begin
            rx_next = rx_shifted;
          end
          if (bit_reg == 3'd0) begin
            if (opcode == OP_XFER) begin
              state_next    = ST_PUSH;
              out_data_next = {OP_XFER, (cpha ? rx_shifted : rx_reg)};
            end else begin
              state_next = ST_IDLE;
            end
          end else begin
            state_next = ST_SHIFT_LO;
            bit_next   = bit_reg - 3'd1;
            cnt_next   = div_reg;
            if (!cpha) begin
              mosi_next = arg[bit_reg - 3'd1];
            end
          end
        end else begin
          cnt_next = cnt_reg - 8'd1;
        end
      end

      // Wait for room in the output FIFO; out_shift fires on the leaving cycle
      ST_PUSH: begin
        if (!out_full) begin
          state_next = ST_IDLE;
        end
      end

      ST_DELAY: begin
        if (cnt_reg == 8'd0) begin
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_reg - 8'd1;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  // State and pin registers; reset drops any in-flight command
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      cmd_reg      <= 16'h0000;
      div_reg      <= DIV_RESET;
      cnt_reg      <= 8'd0;
      bit_reg      <= 3'd0;
      rx_reg       <= 8'h00;
      mosi_reg     <= 1'b0;
      sck_reg      <= 1'b0;
      cs_reg       <= 1'b1;
      aux_reg      <= 1'b0;
      error_reg    <= 1'b0;
      out_data_reg <= 16'h0000;
    end else begin
      state_reg    <= state_next;
      cmd_reg      <= cmd_next;
      div_reg      <= div_next;
      cnt_reg      <= cnt_next;
      bit_reg      <= bit_next;
      rx_reg       <= rx_next;
      mosi_reg     <= mosi_next;
      sck_reg      <= sck_next;
      cs_reg       <= cs_next;
      aux_reg      <= aux_next;
      error_reg    <= error_next;
      out_data_reg <= out_data_next;
    end
  end

endmodule
